dmem_port_arbiter: RTL and testbench
====================================

Name: dmem_port_arbiter

Overview:
- Shares the single data-memory port between two requesters: the pipeline MEM stage (port P) and a secondary master such as a debug or DMA engine (port D).
- Sits between the MEM stage and data memory.
- P has priority. D is protected from starvation by a wait counter.
- Each access occupies the memory for MEM_LAT cycles. The pipeline is stalled until its own access completes.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
MEM_LAT, 1, cycles one access occupies the memory (>=1)
STARVE_MAX, 4, consecutive denied cycles after which D wins arbitration (>=1)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-low (0 = reset)
p_rd  in  1  pipeline load request
p_wr  in  1  pipeline store request
p_adr  in  ADDR_W  pipeline address (ALU result)
p_wdata  in  DATA_W  pipeline store data
p_rdata  out  DATA_W  pipeline load data
p_stall  out  1  hold pipeline stages up to and including MEM
d_req  in  1  secondary-master request
d_we  in  1  secondary-master write enable
d_adr  in  ADDR_W  secondary-master address
d_wdata  in  DATA_W  secondary-master write data
d_gnt  out  1  one-cycle pulse: D request accepted this cycle
d_rvalid  out  1  one-cycle pulse: d_rdata valid
d_rdata  out  DATA_W  secondary-master read data, registered
mem_read  out  1  to data memory
mem_write  out  1  to data memory
mem_adr  out  ADDR_W  to data memory
mem_wdata  out  DATA_W  to data memory
mem_rdata  in  DATA_W  from data memory, combinational read

Behaviour:
- States: IDLE, OWN_P, OWN_D. Occupancy counter occ counts 0..MEM_LAT-1. Starvation counter wait_cnt counts 0..STARVE_MAX and saturates.
- Arbitration happens only in IDLE and is combinational. The arbitration cycle is occupancy cycle 0 of the winner.
  - D wins if d_req=1 and (no P request, or wait_cnt==STARVE_MAX).
  - Otherwise P wins if p_rd|p_wr.
  - Otherwise the arbiter stays IDLE and all mem_* outputs are 0.
- On a D win:
  - d_gnt=1 for that cycle.
  - d_we/d_adr/d_wdata are latched into an internal request register.
  - D must hold its request stable until d_gnt.
- P request fields are taken live from the pipeline. The pipeline holds them stable because p_stall freezes it.
- If MEM_LAT>1, the state moves to OWN_x and stays there until occ==MEM_LAT-1, then returns to IDLE. Arbitration reopens on the following cycle; there is no back-to-back grant within the final cycle.
- mem_* during occupancy:
  - mem_adr and mem_wdata come from the owner.
  - mem_read = owner read, held for all cycles.
  - mem_write = owner write, asserted ONLY on the last occupancy cycle (exactly one write pulse per access).
- p_rd & p_wr both high is treated as a write.
- p_stall = (p_rd|p_wr) & ~(owner==P & last occupancy cycle).
  - With MEM_LAT=1 and no contention, p_stall=0 (zero added latency).
- p_rdata = mem_rdata when owner==P, else 0.
- d_rdata is captured from mem_rdata on the last cycle of a D read. d_rvalid pulses the next cycle.
  - A D write also pulses d_rvalid as its completion acknowledge; d_rdata is unchanged.
- wait_cnt:
  - Increments each cycle d_req=1 and D is not granted.
  - Clears to 0 on d_gnt.
  - Holds when d_req=0.
- Reset (rst=0, asynchronous, may occur mid-access):
  - State returns to IDLE; occ=0, wait_cnt=0.
  - d_rdata=0, d_gnt=0, d_rvalid=0.
  - mem_read=0, mem_write=0, p_stall=0 while rst=0.
  - An interrupted access is abandoned; no write is issued.

Test Plan:
- MEM_LAT=1, p_wr=1, p_adr=0x10, p_wdata=0xDEADBEEF, no D -> mem_write=1 the same cycle, p_stall=0; next cycle p_rd at 0x10 gives p_rdata=0xDEADBEEF, p_stall=0.
- MEM_LAT=3, p_rd at 0x20 -> p_stall=1 for 2 cycles, 0 on the 3rd; mem_read high all 3 cycles; mem_write never high.
- MEM_LAT=1, p_rd held continuously, d_req=1 from cycle 0, STARVE_MAX=4 -> d_gnt on cycle 4; p_stall=1 that cycle; wait_cnt back to 0; P resumes cycle 5.
- D write 0x55 to 0x40 with no P traffic -> d_gnt on the request cycle; mem_write one cycle; d_rvalid next cycle; D read of 0x40 then returns d_rdata=0x55 with d_rvalid.
- MEM_LAT=3, D write in progress, rst driven low at occupancy cycle 1 -> mem_write never asserted; outputs 0 immediately; after release, state IDLE, memory at that address unchanged.
- p_rd=p_wr=1 simultaneously -> treated as write: mem_write=1, mem_read=0.

Source files
------------

// File: rtl/dmem_port_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_port_arbiter
// Shares one data-memory port between the pipeline MEM stage (P) and a
// secondary master such as a debug/DMA engine (D). P has priority; D wins
// after STARVE_MAX consecutive denied cycles. Each access owns the memory for
// MEM_LAT cycles: reads are held for the whole access, and the write strobe
// fires only on the final cycle, so every access issues exactly one write.
//
// Ports
//   clk, rst                   clock (rising edge), async active-low reset
//   p_rd/p_wr/p_adr/p_wdata    pipeline request (held stable by p_stall)
//   p_rdata, p_stall           pipeline load data, pipeline hold
//   d_req/d_we/d_adr/d_wdata   secondary-master request (held until d_gnt)
//   d_gnt, d_rvalid, d_rdata   accept pulse, completion pulse, read data
//   mem_read/mem_write/mem_adr/mem_wdata/mem_rdata   data-memory port
// -----------------------------------------------------------------------------
module dmem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              p_rd,
    input  logic              p_wr,
    input  logic [ADDR_W-1:0] p_adr,
    input  logic [DATA_W-1:0] p_wdata,
    output logic [DATA_W-1:0] p_rdata,
    output logic              p_stall,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_adr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_adr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int OCC_W  = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam int WAIT_W = $clog2(STARVE_MAX + 1);
    localparam logic [OCC_W-1:0]  OCC_LAST = OCC_W'(MEM_LAT - 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(STARVE_MAX);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_OWN_P = 2'd1,
        ST_OWN_D = 2'd2
    } state_t;

    state_t              r_state;
    logic [OCC_W-1:0]    r_occ;
    logic [WAIT_W-1:0]   r_wait_cnt;
    logic                r_d_we;
    logic [ADDR_W-1:0]   r_d_adr;
    logic [DATA_W-1:0]   r_d_wdata;
    logic [DATA_W-1:0]   r_d_rdata;
    logic                r_d_rvalid;

    logic                w_p_req;
    logic                w_d_win;
    logic                w_p_win;
    logic                w_own_p;
    logic                w_own_d;
    logic [OCC_W-1:0]    w_occ;
    logic                w_last;
    logic                w_d_we;
    logic [ADDR_W-1:0]   w_d_adr;
    logic [DATA_W-1:0]   w_d_wdata;

    // Arbitration, ownership decode and the memory-port / pipeline outputs.
    always_comb begin
        w_p_req   = p_rd | p_wr;
        w_d_win   = 1'b0;
        w_p_win   = 1'b0;
        w_occ     = '0;
        case (r_state)
            ST_IDLE: begin
                // Gated by rst so nothing is granted or driven while held in reset.
                w_d_win = rst & d_req & (~w_p_req | (r_wait_cnt == WAIT_MAX));
                w_p_win = rst & ~w_d_win & w_p_req;
                w_occ   = '0;
            end
            ST_OWN_P: w_occ = r_occ;
            ST_OWN_D: w_occ = r_occ;
            default:  w_occ = '0;
        endcase

        w_own_p = w_p_win | (r_state == ST_OWN_P);
        w_own_d = w_d_win | (r_state == ST_OWN_D);
        w_last  = (w_occ == OCC_LAST);

        // On the grant cycle the request register is not loaded yet, so use the live fields.
        if (r_state == ST_IDLE) begin
            w_d_we    = d_we;
            w_d_adr   = d_adr;
            w_d_wdata = d_wdata;
        end else begin
            w_d_we    = r_d_we;
            w_d_adr   = r_d_adr;
            w_d_wdata = r_d_wdata;
        end

        if (w_own_p) begin
            mem_adr   = p_adr;
            mem_wdata = p_wdata;
            mem_read  = p_rd & ~p_wr;
            mem_write = p_wr & w_last;
            p_rdata   = mem_rdata;
        end else if (w_own_d) begin
            mem_adr   = w_d_adr;
            mem_wdata = w_d_wdata;
            mem_read  = ~w_d_we;
            mem_write = w_d_we & w_last;
            p_rdata   = '0;
        end else begin
            mem_adr   = '0;
            mem_wdata = '0;
            mem_read  = 1'b0;
            mem_write = 1'b0;
            p_rdata   = '0;
        end

        p_stall  = rst & w_p_req & ~(w_own_p & w_last);
        d_gnt    = w_d_win;
        d_rdata  = r_d_rdata;
        d_rvalid = r_d_rvalid;
    end

    // Ownership FSM, D request capture, D completion and starvation counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= ST_IDLE;
            r_occ      <= '0;
            r_wait_cnt <= '0;
            r_d_we     <= 1'b0;
            r_d_adr    <= '0;
            r_d_wdata  <= '0;
            r_d_rdata  <= '0;
            r_d_rvalid <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_d_win) begin
                        r_d_we    <= d_we;
                        r_d_adr   <= d_adr;
                        r_d_wdata <= d_wdata;
                        if (OCC_LAST != '0) begin
                            r_state <= ST_OWN_D;
                            r_occ   <= OCC_W'(1);
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end else if (w_p_win && (OCC_LAST != '0)) begin
                        r_state <= ST_OWN_P;
                        r_occ   <= OCC_W'(1);
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_OWN_P, ST_OWN_D: begin
                    if (w_last) begin
                        r_state <= ST_IDLE;
                        r_occ   <= '0;
                    end else begin
                        r_occ   <= r_occ + OCC_W'(1);
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_occ   <= '0;
                end
            endcase

            // A finished D access acknowledges next cycle; only reads update d_rdata.
            r_d_rvalid <= w_own_d & w_last;
            if (w_own_d && w_last && !w_d_we) begin
                r_d_rdata <= mem_rdata;
            end

            if (w_d_win) begin
                r_wait_cnt <= '0;
            end else if (d_req && (r_wait_cnt != WAIT_MAX)) begin
                r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dmem_port_arbiter
// Two arbiters side by side: lane 0 with MEM_LAT=1, lane 1 with MEM_LAT=3
// (STARVE_MAX=4 on both). Each lane has its own behavioural memory. A model
// tracking the owner and the cycles remaining in its access predicts every
// output each cycle; directed steps additionally pin hand-computed values.
// -----------------------------------------------------------------------------
module tb_dmem_port_arbiter;

    localparam int C_MW  = 1;
    localparam int C_MR  = 2;
    localparam int C_ST  = 3;
    localparam int C_PRD = 4;
    localparam int C_GNT = 5;
    localparam int C_RV  = 6;
    localparam int C_DRD = 7;
    localparam int C_M40 = 8;

    typedef struct {
        int          lane;
        int          code;
        logic [31:0] val;
        string       nm;
    } pin_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        init_done;
    logic        p_rd [2];
    logic        p_wr [2];
    logic [31:0] p_adr [2];
    logic [31:0] p_wdata [2];
    logic [31:0] p_rdata [2];
    logic        p_stall [2];
    logic        d_req [2];
    logic        d_we [2];
    logic [31:0] d_adr [2];
    logic [31:0] d_wdata [2];
    logic        d_gnt [2];
    logic        d_rvalid [2];
    logic [31:0] d_rdata [2];
    logic        mem_read [2];
    logic        mem_write [2];
    logic [31:0] mem_adr [2];
    logic [31:0] mem_wdata [2];
    logic [31:0] mem_rdata [2];
    logic [31:0] bmem [2][256];

    pin_t pin_q[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;

    dmem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1), .STARVE_MAX(4)) u_lat1 (
        .clk(clk), .rst(rst),
        .p_rd(p_rd[0]), .p_wr(p_wr[0]), .p_adr(p_adr[0]), .p_wdata(p_wdata[0]),
        .p_rdata(p_rdata[0]), .p_stall(p_stall[0]),
        .d_req(d_req[0]), .d_we(d_we[0]), .d_adr(d_adr[0]), .d_wdata(d_wdata[0]),
        .d_gnt(d_gnt[0]), .d_rvalid(d_rvalid[0]), .d_rdata(d_rdata[0]),
        .mem_read(mem_read[0]), .mem_write(mem_write[0]), .mem_adr(mem_adr[0]),
        .mem_wdata(mem_wdata[0]), .mem_rdata(mem_rdata[0])
    );

    dmem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(3), .STARVE_MAX(4)) u_lat3 (
        .clk(clk), .rst(rst),
        .p_rd(p_rd[1]), .p_wr(p_wr[1]), .p_adr(p_adr[1]), .p_wdata(p_wdata[1]),
        .p_rdata(p_rdata[1]), .p_stall(p_stall[1]),
        .d_req(d_req[1]), .d_we(d_we[1]), .d_adr(d_adr[1]), .d_wdata(d_wdata[1]),
        .d_gnt(d_gnt[1]), .d_rvalid(d_rvalid[1]), .d_rdata(d_rdata[1]),
        .mem_read(mem_read[1]), .mem_write(mem_write[1]), .mem_adr(mem_adr[1]),
        .mem_wdata(mem_wdata[1]), .mem_rdata(mem_rdata[1])
    );

    assign mem_rdata[0] = bmem[0][mem_adr[0][7:0]];
    assign mem_rdata[1] = bmem[1][mem_adr[1][7:0]];

    // Behavioural data memories, one per lane, written on the DUT's strobe.
    always @(posedge clk) begin
        for (int g = 0; g < 2; g++) begin
            if (!init_done) begin
                for (int a = 0; a < 256; a++) bmem[g][a] <= 32'd0;
            end else if (mem_write[g]) begin
                bmem[g][mem_adr[g][7:0]] <= mem_wdata[g];
            end
        end
    end

    task automatic chk(input string nm, input int lane, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s lane%0d: actual %h, required %h", nm, lane, act, exp);
    endtask

    function automatic logic [31:0] pin_act(input int lane, input int code);
        case (code)
            C_MW:    return {31'd0, mem_write[lane]};
            C_MR:    return {31'd0, mem_read[lane]};
            C_ST:    return {31'd0, p_stall[lane]};
            C_PRD:   return p_rdata[lane];
            C_GNT:   return {31'd0, d_gnt[lane]};
            C_RV:    return {31'd0, d_rvalid[lane]};
            C_DRD:   return d_rdata[lane];
            C_M40:   return bmem[lane][8'h40];
            default: return 32'hFFFF_FFFF;
        endcase
    endfunction

    // Model and compare: runs mid-cycle, predicts this cycle, then steps the model.
    initial begin : cmp
        int          m_owner [2];   // 0 none, 1 P, 2 D
        int          m_left [2];    // cycles still to go after the current one
        int          m_wait [2];
        logic        m_dwe [2];
        logic [31:0] m_dadr [2];
        logic [31:0] m_dwd [2];
        logic [31:0] m_drdata [2];
        logic        m_rv [2];
        logic [31:0] m_mem [2][256];
        int          own, left, lat;
        logic        preq, gnt, last, erd, ewr;
        logic [31:0] eadr, ewd, eprd;
        forever begin
            @(negedge clk);
            for (int g = 0; g < 2; g++) begin
                lat = (g == 0) ? 1 : 3;
                if (!init_done) begin
                    for (int a = 0; a < 256; a++) m_mem[g][a] = 32'd0;
                end
                if (!rst) begin
                    chk("rst_mem_read", g, {31'd0, mem_read[g]}, 32'd0);
                    chk("rst_mem_write", g, {31'd0, mem_write[g]}, 32'd0);
                    chk("rst_p_stall", g, {31'd0, p_stall[g]}, 32'd0);
                    chk("rst_d_gnt", g, {31'd0, d_gnt[g]}, 32'd0);
                    chk("rst_d_rvalid", g, {31'd0, d_rvalid[g]}, 32'd0);
                    chk("rst_d_rdata", g, d_rdata[g], 32'd0);
                    m_owner[g] = 0; m_left[g] = 0; m_wait[g] = 0;
                    m_dwe[g] = 1'b0; m_dadr[g] = 32'd0; m_dwd[g] = 32'd0;
                    m_drdata[g] = 32'd0; m_rv[g] = 1'b0;
                end else begin
                    preq = p_rd[g] | p_wr[g];
                    gnt  = 1'b0;
                    if (m_owner[g] == 0) begin
                        gnt = d_req[g] && (!preq || m_wait[g] == 4);
                        if (gnt) begin
                            own = 2; left = lat - 1;
                            m_dwe[g] = d_we[g]; m_dadr[g] = d_adr[g]; m_dwd[g] = d_wdata[g];
                        end else if (preq) begin
                            own = 1; left = lat - 1;
                        end else begin
                            own = 0; left = 0;
                        end
                    end else begin
                        own = m_owner[g]; left = m_left[g];
                    end
                    last = (own != 0) && (left == 0);
                    if (own == 1) begin
                        eadr = p_adr[g]; ewd = p_wdata[g];
                        erd = p_rd[g] & ~p_wr[g]; ewr = p_wr[g];
                        eprd = m_mem[g][p_adr[g][7:0]];
                    end else if (own == 2) begin
                        eadr = m_dadr[g]; ewd = m_dwd[g];
                        erd = ~m_dwe[g]; ewr = m_dwe[g]; eprd = 32'd0;
                    end else begin
                        eadr = 32'd0; ewd = 32'd0; erd = 1'b0; ewr = 1'b0; eprd = 32'd0;
                    end
                    chk("mem_read", g, {31'd0, mem_read[g]}, {31'd0, erd});
                    chk("mem_write", g, {31'd0, mem_write[g]}, {31'd0, ewr && last});
                    chk("mem_adr", g, mem_adr[g], eadr);
                    chk("mem_wdata", g, mem_wdata[g], ewd);
                    chk("p_rdata", g, p_rdata[g], eprd);
                    chk("p_stall", g, {31'd0, p_stall[g]}, {31'd0, preq && !(own == 1 && last)});
                    chk("d_gnt", g, {31'd0, d_gnt[g]}, {31'd0, gnt});
                    chk("d_rvalid", g, {31'd0, d_rvalid[g]}, {31'd0, m_rv[g]});
                    chk("d_rdata", g, d_rdata[g], m_drdata[g]);
                    m_rv[g] = (own == 2) && last;
                    if (last) begin
                        if (own == 2 && !ewr) m_drdata[g] = m_mem[g][eadr[7:0]];
                        if (ewr) m_mem[g][eadr[7:0]] = ewd;
                        m_owner[g] = 0;
                    end else begin
                        m_owner[g] = own;
                        m_left[g]  = (own != 0) ? left - 1 : 0;
                    end
                    if (gnt) m_wait[g] = 0;
                    else if (d_req[g] && m_wait[g] < 4) m_wait[g] = m_wait[g] + 1;
                end
            end
            foreach (pin_q[i]) begin
                chk(pin_q[i].nm, pin_q[i].lane, pin_act(pin_q[i].lane, pin_q[i].code), pin_q[i].val);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        pin_q.delete();
    endtask

    task automatic pin(input int lane, input int code, input logic [31:0] v, input string nm);
        pin_t p;
        p.lane = lane; p.code = code; p.val = v; p.nm = nm;
        pin_q.push_back(p);
    endtask

    // Directed stimulus with hand-computed pins.
    initial begin
        rst = 1'b0;
        init_done = 1'b0;
        for (int g = 0; g < 2; g++) begin
            p_rd[g] = 1'b0; p_wr[g] = 1'b0; p_adr[g] = 32'd0; p_wdata[g] = 32'd0;
            d_req[g] = 1'b0; d_we[g] = 1'b0; d_adr[g] = 32'd0; d_wdata[g] = 32'd0;
        end
        tick(); tick();
        init_done = 1'b1;
        tick();
        rst = 1'b1;
        tick();

        // Lane 0, MEM_LAT=1: zero-latency store then load.
        p_wr[0] = 1'b1; p_adr[0] = 32'h10; p_wdata[0] = 32'hDEADBEEF;
        pin(0, C_MW, 32'd1, "st_write_now"); pin(0, C_ST, 32'd0, "st_no_stall");
        tick();
        p_wr[0] = 1'b0; p_rd[0] = 1'b1;
        pin(0, C_PRD, 32'hDEADBEEF, "ld_data"); pin(0, C_ST, 32'd0, "ld_no_stall");
        tick();
        // Both strobes high: a write.
        p_wr[0] = 1'b1; p_adr[0] = 32'h14; p_wdata[0] = 32'h12345678;
        pin(0, C_MW, 32'd1, "both_is_write"); pin(0, C_MR, 32'd0, "both_no_read");
        tick();
        // Starvation: P reads continuously, D read waits 4 cycles.
        p_wr[0] = 1'b0; p_adr[0] = 32'h10;
        d_req[0] = 1'b1; d_we[0] = 1'b0; d_adr[0] = 32'h14;
        for (int c = 0; c < 5; c++) begin
            pin(0, C_GNT, (c == 4) ? 32'd1 : 32'd0, "starve_gnt");
            if (c == 4) pin(0, C_ST, 32'd1, "starve_stall");
            tick();
        end
        d_req[0] = 1'b0;
        pin(0, C_ST, 32'd0, "p_resume"); pin(0, C_RV, 32'd1, "dread_rvalid");
        pin(0, C_DRD, 32'h12345678, "dread_data");
        tick();
        p_rd[0] = 1'b0;
        tick();
        // D write then read back, no P traffic.
        d_req[0] = 1'b1; d_we[0] = 1'b1; d_adr[0] = 32'h40; d_wdata[0] = 32'h55;
        pin(0, C_GNT, 32'd1, "dwr_gnt"); pin(0, C_MW, 32'd1, "dwr_strobe");
        tick();
        d_req[0] = 1'b0; d_we[0] = 1'b0;
        pin(0, C_RV, 32'd1, "dwr_ack"); pin(0, C_MW, 32'd0, "dwr_single");
        tick();
        d_req[0] = 1'b1;
        pin(0, C_GNT, 32'd1, "drd_gnt"); pin(0, C_MR, 32'd1, "drd_read");
        tick();
        d_req[0] = 1'b0;
        pin(0, C_RV, 32'd1, "drd_rvalid"); pin(0, C_DRD, 32'h55, "drd_data");
        tick(); tick();

        // Lane 1, MEM_LAT=3: store, then load with two stall cycles.
        p_wr[1] = 1'b1; p_adr[1] = 32'h20; p_wdata[1] = 32'hA5A5A5A5;
        for (int c = 0; c < 3; c++) begin
            pin(1, C_ST, (c < 2) ? 32'd1 : 32'd0, "l3_st_stall");
            pin(1, C_MW, (c == 2) ? 32'd1 : 32'd0, "l3_st_strobe");
            tick();
        end
        p_wr[1] = 1'b0; p_rd[1] = 1'b1;
        for (int c = 0; c < 3; c++) begin
            pin(1, C_ST, (c < 2) ? 32'd1 : 32'd0, "l3_ld_stall");
            pin(1, C_MR, 32'd1, "l3_ld_read"); pin(1, C_MW, 32'd0, "l3_ld_nowrite");
            if (c == 2) pin(1, C_PRD, 32'hA5A5A5A5, "l3_ld_data");
            tick();
        end
        p_rd[1] = 1'b0; p_wr[1] = 1'b1; p_adr[1] = 32'h40; p_wdata[1] = 32'h0BADF00D;
        tick(); tick(); tick();
        p_wr[1] = 1'b0;
        tick();
        // D write interrupted by reset at occupancy cycle 1.
        d_req[1] = 1'b1; d_we[1] = 1'b1; d_adr[1] = 32'h40; d_wdata[1] = 32'h77;
        pin(1, C_GNT, 32'd1, "abort_gnt"); pin(1, C_MW, 32'd0, "abort_occ0_nowrite");
        tick();
        d_req[1] = 1'b0; d_we[1] = 1'b0;
        rst = 1'b0;
        pin(1, C_MW, 32'd0, "abort_rst_nowrite"); pin(1, C_GNT, 32'd0, "abort_rst_gnt");
        tick();
        pin(1, C_MW, 32'd0, "abort_rst_nowrite2");
        tick();
        rst = 1'b1;
        tick();
        pin(1, C_M40, 32'h0BADF00D, "abort_mem_kept");
        p_rd[1] = 1'b1; p_adr[1] = 32'h40;
        for (int c = 0; c < 3; c++) begin
            if (c == 2) pin(1, C_PRD, 32'h0BADF00D, "abort_readback");
            tick();
        end
        p_rd[1] = 1'b0;
        tick();
        // Sustained contention on the 3-cycle lane.
        p_rd[1] = 1'b1; p_adr[1] = 32'h20;
        d_req[1] = 1'b1; d_we[1] = 1'b0; d_adr[1] = 32'h20;
        for (int c = 0; c < 24; c++) tick();
        p_rd[1] = 1'b0; d_req[1] = 1'b0;
        tick(); tick(); tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
